// File: rtl/rx_pkt_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkt_pkg
//   Shared definitions for the RX packet parser: buffer/field geometry, packet
//   type codes, word offsets inside a packet, the parser FSM state encoding and
//   the packed field set presented to QTU_FMB.
// -----------------------------------------------------------------------------
package rx_pkt_pkg;

  // RX buffer geometry
  localparam int MEM_WIDTH  = 8;
  localparam int MEM_DEPTH  = 2048;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

  // Packet geometry: big-endian 16-bit words, two bytes each
  localparam int WORD_WIDTH = 16;
  localparam int PKT_BYTES  = 16;
  localparam int PKT_WORDS  = PKT_BYTES / 2;
  localparam int BCNT_WIDTH = $clog2(PKT_BYTES);

  // Downstream handshake timeout
  localparam int DONE_TIMEOUT = 1023;
  localparam int TMO_WIDTH    = 10;

  // Packet type codes carried in word 0
  localparam logic [WORD_WIDTH-1:0] PKT_TYPE_HEARTBEAT = 16'h0001;
  localparam logic [WORD_WIDTH-1:0] PKT_TYPE_CLUSTER   = 16'h0002;

  // Word position of each field inside a packet
  typedef enum logic [2:0] {
    W_TYPE         = 3'd0,
    W_SOURCE_ID    = 3'd1,
    W_SOURCE_HOPS  = 3'd2,
    W_QVALUE       = 3'd3,
    W_ENERGY_LEFT  = 3'd4,
    W_HOPS_FROM_CH = 3'd5,
    W_CHOSEN_CH    = 3'd6,
    W_DEST_ID      = 3'd7
  } word_idx_e;

  // Parser FSM states
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH     = 2'd1,
    S_DECODE    = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  // Field set held stable for QTU_FMB between cluster decodes
  typedef struct packed {
    logic [WORD_WIDTH-1:0] source_id;
    logic [WORD_WIDTH-1:0] source_hops;
    logic [WORD_WIDTH-1:0] q_value;
    logic [WORD_WIDTH-1:0] energy_left;
    logic [WORD_WIDTH-1:0] hops_from_ch;
    logic [WORD_WIDTH-1:0] chosen_ch;
  } field_set_t;

  // Extract one word from the flattened shadow array (word 0 in the low bits)
  function automatic logic [WORD_WIDTH-1:0] get_word(
    input logic [PKT_WORDS*WORD_WIDTH-1:0] words,
    input word_idx_e                       idx
  );
    return words[int'(idx)*WORD_WIDTH +: WORD_WIDTH];
  endfunction

endpackage

// File: rtl/rx_word_assembler.sv
// -----------------------------------------------------------------------------
// rx_word_assembler
//   Collects the byte stream of one packet into eight big-endian 16-bit words.
//   Even byte offsets land in the word MSB, odd offsets in the LSB.
//
//   clk          in   clock, rising edge
//   nrst         in   asynchronous active-low reset
//   start_i      in   clears the byte counter for a new packet
//   byte_valid_i in   byte_i carries the next packet byte
//   byte_i       in   packet byte
//   words_o      out  8 x 16-bit words, word 0 in bits [15:0]
//   last_o       out  high while the final byte of the packet is being captured
// -----------------------------------------------------------------------------
module rx_word_assembler
  import rx_pkt_pkg::*;
(
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            start_i,
  input  logic                            byte_valid_i,
  input  logic [MEM_WIDTH-1:0]            byte_i,
  output logic [PKT_WORDS*WORD_WIDTH-1:0] words_o,
  output logic                            last_o
);

  logic [BCNT_WIDTH-1:0]                 byte_cnt_q;
  logic [PKT_WORDS-1:0][WORD_WIDTH-1:0]  shadow_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      byte_cnt_q <= '0;
    end else if (start_i) begin
      byte_cnt_q <= '0;
    end else if (byte_valid_i) begin
      byte_cnt_q <= byte_cnt_q + 1'b1;
    end
  end

  // NOTE: the shadow array has no reset; every word is rewritten before the
  // packet is decoded, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (byte_valid_i) begin
      if (!byte_cnt_q[0]) begin
        shadow_q[byte_cnt_q[BCNT_WIDTH-1:1]][WORD_WIDTH-1:MEM_WIDTH] <= byte_i;
      end else begin
        shadow_q[byte_cnt_q[BCNT_WIDTH-1:1]][MEM_WIDTH-1:0] <= byte_i;
      end
    end
  end

  assign words_o = shadow_q;

  // Flags the capture edge of the last byte so the FSM can step to DECODE
  // on the same edge, leaving the shadow complete during DECODE.
  assign last_o = byte_valid_i && (byte_cnt_q == BCNT_WIDTH'(PKT_BYTES - 1));

endmodule

// File: rtl/rx_pkt_parser.sv
// -----------------------------------------------------------------------------
// rx_pkt_parser
//   Reads one 16-byte packet from the byte-wide RX buffer, decodes its type and
//   presents the parsed fields to QTU_FMB. A cluster packet updates all fields
//   and strobes en, then waits for QTUFMB_done (with a timeout). A heartbeat
//   updates fSourceID only and strobes HB_Reset. Unknown types strobe drop_err.
//
//   clk, nrst                 clock / asynchronous active-low reset
//   myNodeID                  this node's ID, compared with the packet DestID
//   pkt_valid, pkt_base       packet available at byte address pkt_base
//   pkt_ack                   1-cycle pulse when a packet is accepted
//   mem_rd, mem_addr          RX buffer read strobe and byte address
//   mem_rdata                 RX buffer data, valid the cycle after mem_rd
//   QTUFMB_done               downstream has consumed the cluster fields
//   en, HB_Reset              1-cycle cluster / heartbeat strobes
//   iAmDestination            DestID matched myNodeID (valid with en)
//   fSourceID..fChosenCH      parsed fields, held until the next cluster decode
//   busy                      FSM is not idle
//   drop_err, timeout_err     1-cycle error strobes
// -----------------------------------------------------------------------------
module rx_pkt_parser
  import rx_pkt_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic                  pkt_valid,
  input  logic [ADDR_WIDTH-1:0] pkt_base,
  output logic                  pkt_ack,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_WIDTH-1:0]  mem_rdata,
  input  logic                  QTUFMB_done,
  output logic                  en,
  output logic                  HB_Reset,
  output logic                  iAmDestination,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fSourceHops,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fHopsFromCH,
  output logic [WORD_WIDTH-1:0] fChosenCH,
  output logic                  busy,
  output logic                  drop_err,
  output logic                  timeout_err
);

  localparam logic [TMO_WIDTH-1:0]  TMO_LIMIT = TMO_WIDTH'(DONE_TIMEOUT);
  localparam logic [BCNT_WIDTH-1:0] LAST_RD   = BCNT_WIDTH'(PKT_BYTES - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [BCNT_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic                    rd_vld_q;
  logic [TMO_WIDTH-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [TMO_WIDTH-1:0]    tmo_inc;
  field_set_t              fields_q, fields_d;
  logic                    i_am_dest_q, i_am_dest_d;
  logic                    pkt_ack_q, pkt_ack_d;
  logic                    en_q, en_d;
  logic                    hb_q, hb_d;
  logic                    drop_q, drop_d;
  logic                    tmo_err_q, tmo_err_d;

  logic                    asm_start;
  logic                    asm_last;
  logic [PKT_WORDS*WORD_WIDTH-1:0] words;
  logic [WORD_WIDTH-1:0]   pkt_type;

  // Byte capture: the buffer answers one cycle after each read strobe.
  rx_word_assembler u_asm (
    .clk          (clk),
    .nrst         (nrst),
    .start_i      (asm_start),
    .byte_valid_i (rd_vld_q),
    .byte_i       (mem_rdata),
    .words_o      (words),
    .last_o       (asm_last)
  );

  assign pkt_type = get_word(words, W_TYPE);
  assign tmo_inc  = tmo_cnt_q + 1'b1;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mem_rd_d    = 1'b0;
    rd_cnt_d    = rd_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    fields_d    = fields_q;
    i_am_dest_d = i_am_dest_q;
    pkt_ack_d   = 1'b0;
    en_d        = 1'b0;
    hb_d        = 1'b0;
    drop_d      = 1'b0;
    tmo_err_d   = 1'b0;
    asm_start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pkt_valid) begin
          asm_start = 1'b1;
          pkt_ack_d = 1'b1;
          mem_rd_d  = 1'b1;
          addr_d    = pkt_base;
          rd_cnt_d  = '0;
          state_d   = S_FETCH;
        end
      end

      S_FETCH: begin
        // Address increments wrap naturally at the buffer end (2047 -> 0).
        if (mem_rd_q && (rd_cnt_q != LAST_RD)) begin
          mem_rd_d = 1'b1;
          addr_d   = addr_q + 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (asm_last) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (pkt_type == PKT_TYPE_CLUSTER) begin
          fields_d.source_id    = get_word(words, W_SOURCE_ID);
          fields_d.source_hops  = get_word(words, W_SOURCE_HOPS);
          fields_d.q_value      = get_word(words, W_QVALUE);
          fields_d.energy_left  = get_word(words, W_ENERGY_LEFT);
          fields_d.hops_from_ch = get_word(words, W_HOPS_FROM_CH);
          fields_d.chosen_ch    = get_word(words, W_CHOSEN_CH);
          i_am_dest_d           = (get_word(words, W_DEST_ID) == myNodeID);
          en_d                  = 1'b1;
          tmo_cnt_d             = '0;
          state_d               = S_WAIT_DONE;
        end else if (pkt_type == PKT_TYPE_HEARTBEAT) begin
          fields_d.source_id = get_word(words, W_SOURCE_ID);
          hb_d               = 1'b1;
          state_d            = S_IDLE;
        end else begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WAIT_DONE: begin
        // done coinciding with the en strobe belongs to no transaction yet.
        if (QTUFMB_done && !en_q) begin
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_inc;
          if (tmo_inc == TMO_LIMIT) begin
            tmo_err_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mem_rd_q    <= 1'b0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      fields_q    <= '0;
      i_am_dest_q <= 1'b0;
      pkt_ack_q   <= 1'b0;
      en_q        <= 1'b0;
      hb_q        <= 1'b0;
      drop_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mem_rd_q    <= mem_rd_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_vld_q    <= mem_rd_q;
      tmo_cnt_q   <= tmo_cnt_d;
      fields_q    <= fields_d;
      i_am_dest_q <= i_am_dest_d;
      pkt_ack_q   <= pkt_ack_d;
      en_q        <= en_d;
      hb_q        <= hb_d;
      drop_q      <= drop_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign pkt_ack        = pkt_ack_q;
  assign mem_rd         = mem_rd_q;
  assign mem_addr       = addr_q;
  assign en             = en_q;
  assign HB_Reset       = hb_q;
  assign drop_err       = drop_q;
  assign timeout_err    = tmo_err_q;
  assign iAmDestination = i_am_dest_q;
  assign busy           = (state_q != S_IDLE);

  assign fSourceID   = fields_q.source_id;
  assign fSourceHops = fields_q.source_hops;
  assign fQValue     = fields_q.q_value;
  assign fEnergyLeft = fields_q.energy_left;
  assign fHopsFromCH = fields_q.hops_from_ch;
  assign fChosenCH   = fields_q.chosen_ch;

endmodule

// File: tb/tb_rx_pkt_parser.sv
// -----------------------------------------------------------------------------
// tb_rx_pkt_parser
//   Scoreboarded bench for rx_pkt_parser. The stimulus thread writes packets
//   into a behavioural RX buffer and pushes the expected strobe (kind, cycle,
//   field set) into a queue; a negedge monitor pops and compares whenever the
//   DUT raises en, HB_Reset, drop_err or timeout_err.
//   Cycle numbering: cyc counts rising edges; a registered output set by edge
//   k is observed at the following falling edge with cyc == k.
// -----------------------------------------------------------------------------
module tb_rx_pkt_parser;

  localparam int TMO = 1023;

  typedef enum int {EV_EN, EV_HB, EV_DROP, EV_TMO} ev_e;
  typedef struct {
    ev_e         kind;
    int          cyc;
    logic [95:0] f;
    logic        iam;
  } exp_t;
  typedef struct {
    int          edge_n;
    logic [10:0] addr;
  } rd_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] myNodeID = 16'd7;
  logic        pkt_valid = 1'b0;
  logic [10:0] pkt_base = '0;
  logic        pkt_ack;
  logic        mem_rd;
  logic [10:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        QTUFMB_done = 1'b0;
  logic        en, HB_Reset, iAmDestination, busy, drop_err, timeout_err;
  logic [15:0] fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH;

  logic [7:0]  mem [0:2047];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          ack_count = 0;
  int          ev_count = 0;
  exp_t        exp_q [$];
  rd_t         rd_log [$];
  logic [95:0] model_f = '0;
  logic        model_iam = 1'b0;
  logic [4:0]  pv, prev_pv = '0;
  exp_t        e_mon;
  ev_e         act_kind;

  rx_pkt_parser dut (
    .clk(clk), .nrst(nrst), .myNodeID(myNodeID),
    .pkt_valid(pkt_valid), .pkt_base(pkt_base), .pkt_ack(pkt_ack),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .QTUFMB_done(QTUFMB_done), .en(en), .HB_Reset(HB_Reset),
    .iAmDestination(iAmDestination),
    .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fQValue(fQValue),
    .fEnergyLeft(fEnergyLeft), .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH),
    .busy(busy), .drop_err(drop_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read RX buffer; each read is logged with the edge that took it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_log.push_back('{cyc + 1, mem_addr});
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [95:0] dut_fields();
    return {fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH};
  endfunction

  // Monitor: pulse hygiene plus scoreboard pop on every strobe.
  always @(negedge clk) begin
    pv = {pkt_ack, en, HB_Reset, drop_err, timeout_err};
    if (nrst) begin
      if (pkt_ack) ack_count++;
      if (|pv) begin
        check("pulse_onehot", 128'($countones(pv)), 128'd1);
        check("pulse_width", 128'(pv & prev_pv), 128'd0);
      end
      if (en || HB_Reset || drop_err || timeout_err) begin
        ev_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", 128'(pv), 128'd0);
        end else begin
          e_mon = exp_q.pop_front();
          act_kind = en ? EV_EN : HB_Reset ? EV_HB : drop_err ? EV_DROP : EV_TMO;
          check("event_kind", 128'(act_kind), 128'(e_mon.kind));
          check("event_cycle", 128'(cyc), 128'(e_mon.cyc));
          check("event_fields", 128'(dut_fields()), 128'(e_mon.f));
          check("event_iam", 128'(iAmDestination), 128'(e_mon.iam));
        end
      end
      prev_pv = pv;
    end else begin
      prev_pv = '0;
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic load_pkt(input logic [10:0] base, input logic [7:0][15:0] w);
    logic [15:0] wd;
    for (int i = 0; i < 16; i++) begin
      wd = w[i >> 1];
      mem[(int'(base) + i) % 2048] = (i % 2 == 0) ? wd[15:8] : wd[7:0];
    end
  endtask

  // done_dly >= 1: QTUFMB_done driven done_dly cycles after en; < 0: never.
  task automatic send_pkt(input logic [10:0] base, input logic [7:0][15:0] w,
                          input int done_dly, input bit hold_valid);
    int   t0;
    int   acks0;
    exp_t e;
    bit   is_cluster;
    load_pkt(base, w);
    rd_log.delete();
    acks0 = ack_count;
    pkt_base  = base;
    pkt_valid = 1'b1;
    t0 = -1;
    for (int n = 0; n < 50 && t0 < 0; n++) begin
      @(negedge clk);
      if (pkt_ack) t0 = cyc;
    end
    if (t0 < 0) begin
      check("ack_timeout", 128'd0, 128'd1);
      pkt_valid = 1'b0;
      return;
    end
    if (!hold_valid) pkt_valid = 1'b0;

    // Reference model: effect of the packet on the field set, by type.
    is_cluster = (w[0] == 16'h0002);
    if (is_cluster) begin
      model_f   = {w[1], w[2], w[3], w[4], w[5], w[6]};
      model_iam = (w[7] == myNodeID);
      e.kind    = EV_EN;
    end else if (w[0] == 16'h0001) begin
      model_f[95:80] = w[1];
      e.kind         = EV_HB;
    end else begin
      e.kind = EV_DROP;
    end
    e.cyc = t0 + 18;
    e.f   = model_f;
    e.iam = model_iam;
    exp_q.push_back(e);
    if (is_cluster && done_dly < 0) begin
      e.kind = EV_TMO;
      e.cyc  = t0 + 18 + TMO;
      exp_q.push_back(e);
    end

    wait_cyc(t0 + 17);
    pkt_valid = 1'b0;
    wait_cyc(t0 + 18);
    if (is_cluster && done_dly >= 0) begin
      wait_cyc(t0 + 18 + done_dly);
      check("busy_wait_done", 128'(busy), 128'd1);
      QTUFMB_done = 1'b1;
      @(negedge clk);
      QTUFMB_done = 1'b0;
      check("idle_after_done", 128'(busy), 128'd0);
    end else if (is_cluster) begin
      wait_cyc(t0 + 18 + TMO - 1);
      check("busy_before_tmo", 128'(busy), 128'd1);
      wait_cyc(t0 + 18 + TMO);
      check("idle_after_tmo", 128'(busy), 128'd0);
    end else begin
      check("idle_after_decode", 128'(busy), 128'd0);
    end
    @(negedge clk);
    check("ack_once", 128'(ack_count - acks0), 128'd1);
    check("events_drained", 128'(exp_q.size()), 128'd0);
    check("rd_count", 128'(rd_log.size()), 128'd16);
    for (int i = 0; i < rd_log.size() && i < 16; i++) begin
      check("rd_addr", 128'(rd_log[i].addr), 128'((int'(base) + i) % 2048));
      check("rd_edge", 128'(rd_log[i].edge_n), 128'(t0 + 1 + i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][15:0] w;
    int t0;
    int ev0;
    int kind;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 37 + 11);

    // 1: reset, then idle with pkt_valid low
    repeat (3) @(negedge clk);
    check("rst_ctrl", 128'({pkt_ack, en, HB_Reset, drop_err, timeout_err, mem_rd, busy, iAmDestination}), 128'd0);
    check("rst_addr", 128'(mem_addr), 128'd0);
    check("rst_fields", 128'(dut_fields()), 128'd0);
    nrst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_reads", 128'(rd_log.size()), 128'd0);
    check("idle_not_busy", 128'(busy), 128'd0);

    // 2: cluster at 0x010, destined to this node, done at t25
    w = {16'd7, 16'd41, 16'd2, 16'h3000, 16'h1000, 16'd3, 16'd41, 16'h0002};
    send_pkt(11'h010, w, 7, 1'b0);

    // 3: heartbeat, only SourceID moves
    w = {16'hDEAD, 16'hBEEF, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'd25, 16'h0001};
    send_pkt(11'h100, w, 0, 1'b0);

    // 4: cluster wrapping the buffer end, not for this node
    w = {16'd9, 16'd25, 16'd2, 16'h3333, 16'h0C00, 16'd2, 16'd65, 16'h0002};
    send_pkt(11'd2040, w, 3, 1'b0);

    // 5: unknown type dropped, pkt_valid held through FETCH
    w = {16'd7, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'h00FF};
    send_pkt(11'h200, w, 0, 1'b1);

    // 6a: cluster never acknowledged by QTU_FMB
    w = {16'd7, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'h0002};
    send_pkt(11'h300, w, -1, 1'b0);

    // 6b: reset mid-fetch aborts without strobes
    w = {16'd7, 16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 16'd26, 16'h0002};
    load_pkt(11'h400, w);
    ev0 = ev_count;
    pkt_base  = 11'h400;
    pkt_valid = 1'b1;
    t0 = -1;
    for (int n = 0; n < 50 && t0 < 0; n++) begin
      @(negedge clk);
      if (pkt_ack) t0 = cyc;
    end
    pkt_valid = 1'b0;
    check("abort_ack_seen", 128'(t0 >= 0), 128'd1);
    wait_cyc(t0 + 8);
    nrst = 1'b0;
    #1;
    check("abort_ctrl", 128'({pkt_ack, en, HB_Reset, drop_err, timeout_err, mem_rd, busy, iAmDestination}), 128'd0);
    check("abort_addr", 128'(mem_addr), 128'd0);
    check("abort_fields", 128'(dut_fields()), 128'd0);
    model_f   = '0;
    model_iam = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_event", 128'(ev_count - ev0), 128'd0);
    check("abort_idle", 128'(busy), 128'd0);
    rd_log.delete();

    // Randomized mix of packet types, bases, node IDs and done delays
    for (int p = 0; p < 14; p++) begin
      kind = int'($urandom_range(0, 2));
      myNodeID = 16'($urandom);
      for (int k = 1; k < 7; k++) w[k] = 16'($urandom);
      w[7] = ($urandom_range(0, 1) == 1) ? myNodeID : 16'($urandom);
      if (kind == 0) w[0] = 16'h0002;
      else if (kind == 1) w[0] = 16'h0001;
      else begin
        w[0] = 16'($urandom);
        if (w[0] == 16'h0001 || w[0] == 16'h0002) w[0] = 16'h8000;
      end
      send_pkt(11'($urandom_range(0, 2047)), w, int'($urandom_range(1, 12)),
               bit'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
